main_mem_tlul_adapter: RTL



---
 rtl/main_mem_tlul_adapter.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/main_mem_tlul_adapter.sv
// TL-UL to req/gnt/rvalid main-memory bridge with in-order responses.
// Build option: MAIN_MEM_PARTIAL_WRITE_EN forwards PutPartialData with any mask.

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    function automatic logic [6:0] intg7(input logic [56:0] d);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 57; i++) begin
            p[3'(i % 7)] = p[3'(i % 7)] ^ d[6'(i)];
        end
        return p;
    endfunction

    function automatic tl_d_user_t rsp_intg_gen(
        input logic [2:0]  op,
        input logic [1:0]  size,
        input logic        err,
        input logic [31:0] data
    );
        tl_d_user_t u;
        u.rsp_intg  = intg7({51'b0, op, size, err});
        u.data_intg = intg7({25'b0, data});
        return u;
    endfunction

endpackage

module main_mem_tlul_adapter
    import tlul_pkg::*;
#(
    parameter logic [31:0] MemBaseAddr    = 32'h8000_0000,
    parameter logic [31:0] MemSize        = 32'd1048576,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    output logic          mem_req_o,
    input  logic          mem_gnt_i,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_rvalid_i,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_err_i,
    output logic          busy_o
);

    localparam int PtrW = $clog2(MaxOutstanding);
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        logic [7:0] source;
        logic [1:0] size;
        logic       is_get;
        logic       local_err;
    } meta_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } cpl_t;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_hold_q, req_hold_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    meta_t           meta_mem [MaxOutstanding];
    cpl_t            cpl_mem  [MaxOutstanding];
    logic [CntW-1:0] mw_q, mr_q, cw_q, cr_q;

    logic        a_ready, a_acc, d_hs;
    logic        op_get, op_pf, op_pp;
    logic        bad_op, bad_size, misalign, out_range;
    logic        mask_err, part_err, local_err;
    logic [31:0] offset;
    logic [3:0]  full_mask;
    meta_t       new_meta, head;
    cpl_t        head_cpl;
    logic        meta_empty, cpl_empty;
    logic        d_valid, d_error;
    logic [31:0] d_data;
    logic [2:0]  d_opcode;
    logic        unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

    // A grant frees the request register in the same cycle it is reloaded.
    assign a_ready = (!req_hold_q || mem_gnt_i) && (cnt_q < CntW'(MaxOutstanding));
    assign a_acc   = tl_i.a_valid && a_ready;
    assign d_hs    = d_valid && tl_i.d_ready;

    assign op_get = (tl_i.a_opcode == Get);
    assign op_pf  = (tl_i.a_opcode == PutFullData);
    assign op_pp  = (tl_i.a_opcode == PutPartialData);
    assign offset = tl_i.a_address - MemBaseAddr;

    always_comb begin
        full_mask = 4'b1111;
        unique case (tl_i.a_size)
            2'd0:    full_mask = 4'b0001 << tl_i.a_address[1:0];
            2'd1:    full_mask = 4'b0011 << {tl_i.a_address[1], 1'b0};
            default: full_mask = 4'b1111;
        endcase
    end

    assign bad_op    = !(op_get || op_pf || op_pp);
    assign bad_size  = (tl_i.a_size > 2'd2);
    assign misalign  = ((tl_i.a_size == 2'd1) && tl_i.a_address[0])
                    || ((tl_i.a_size == 2'd2) && (|tl_i.a_address[1:0]));
    assign out_range = !(offset < MemSize);

`ifdef MAIN_MEM_PARTIAL_WRITE_EN
    assign part_err = 1'b0;
`else
    assign part_err = op_pp && (tl_i.a_mask != full_mask);
`endif

    assign mask_err  = (op_pf && (tl_i.a_mask != full_mask)) || part_err;
    assign local_err = bad_op || bad_size || misalign || out_range || mask_err;

    assign new_meta = '{
        source:    tl_i.a_source,
        size:      tl_i.a_size,
        is_get:    op_get,
        local_err: local_err
    };

    always_comb begin
        cnt_d = cnt_q;
        unique case ({a_acc, d_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        req_hold_d = req_hold_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (req_hold_q && mem_gnt_i) begin
            req_hold_d = 1'b0;
        end
        if (a_acc && !local_err) begin
            req_hold_d = 1'b1;
            we_d       = !op_get;
            be_d       = tl_i.a_mask;
            addr_d     = {offset[31:2], 2'b00};
            wdata_d    = tl_i.a_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            req_hold_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mw_q       <= '0;
            mr_q       <= '0;
            cw_q       <= '0;
            cr_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            req_hold_q <= req_hold_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if (a_acc) begin
                mw_q <= mw_q + 1'b1;
            end
            if (d_hs) begin
                mr_q <= mr_q + 1'b1;
            end
            if (mem_rvalid_i) begin
                cw_q <= cw_q + 1'b1;
            end
            if (d_hs && !head.local_err) begin
                cr_q <= cr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are masked by the empty flags.
    always_ff @(posedge clk_i) begin
        if (a_acc) begin
            meta_mem[mw_q[PtrW-1:0]] <= new_meta;
        end
        if (mem_rvalid_i) begin
            cpl_mem[cw_q[PtrW-1:0]] <= '{rdata: mem_rdata_i, err: mem_err_i};
        end
    end

    assign meta_empty = (mw_q == mr_q);
    assign cpl_empty  = (cw_q == cr_q);
    assign head       = meta_empty ? '0 : meta_mem[mr_q[PtrW-1:0]];
    assign head_cpl   = cpl_empty ? '0 : cpl_mem[cr_q[PtrW-1:0]];

    always_comb begin
        d_valid = 1'b0;
        d_error = 1'b0;
        d_data  = '0;
        if (!meta_empty) begin
            if (head.local_err) begin
                d_valid = 1'b1;
                d_error = 1'b1;
            end else if (!cpl_empty) begin
                d_valid = 1'b1;
                d_error = head_cpl.err;
                d_data  = head.is_get ? head_cpl.rdata : 32'h0;
            end
        end
    end

    assign d_opcode = head.is_get ? AccessAckData : AccessAck;

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = d_opcode;
        tl_o.d_param  = 3'h0;
        tl_o.d_size   = head.size;
        tl_o.d_source = head.source;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = d_data;
        tl_o.d_error  = d_error;
        tl_o.d_user   = rsp_intg_gen(d_opcode, head.size, d_error, d_data);
    end

    assign mem_req_o   = req_hold_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (cnt_q != '0);

endmodule
